// File: rtl/md_scheduler_if.sv
// md_scheduler_if: execute-stage multiply/divide request and result bundle.
//   master (pipeline side) drives: start, op_div, is_sign, src_a, src_b,
//                                  flush, stall_other
//   slave  (md_scheduler) drives:  stall_md, busy, result_valid, hi_out, lo_out
interface md_scheduler_if;
  logic        start;
  logic        op_div;
  logic        is_sign;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_other;
  logic        stall_md;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op_div, is_sign, src_a, src_b, flush, stall_other,
    input  stall_md, busy, result_valid, hi_out, lo_out
  );

  modport slave (
    input  start, op_div, is_sign, src_a, src_b, flush, stall_other,
    output stall_md, busy, result_valid, hi_out, lo_out
  );
endinterface

// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the E stage.
//   clk, rst (synchronous, active-low)
//   md.start/op_div/is_sign/src_a/src_b : request, sampled in IDLE
//   md.flush       : cancel in-flight operation
//   md.stall_other : E frozen by another source; holds DONE
//   md.stall_md    : stall request while accepting or computing
//   md.busy        : MUL or DIV in progress
//   md.result_valid/hi_out/lo_out : HI/LO result for the instruction in E
// Multiply takes MUL_LAT cycles in MUL; divide is a 32-step restoring divider.
module md_scheduler #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  md_scheduler_if.slave md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out as quotient bits shift in
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] diff;
  logic [31:0] step_rem, step_quo, q_fix, r_fix;

  always_comb begin
    ext_a = sign_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b = sign_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = ext_a * ext_b;

    // Partial remainder is always below the divisor, so bit 32 of the
    // difference is a clean borrow flag.
    diff     = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    step_rem = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
    step_quo = {quo_q[30:0], ~diff[32]};
    q_fix    = (sign_q && (a_q[31] ^ b_q[31])) ? -step_quo : step_quo;
    r_fix    = (sign_q && a_q[31]) ? -step_rem : step_rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (md.start && !md.flush) begin
          a_d    = md.src_a;
          b_d    = md.src_b;
          sign_d = md.is_sign;
          if (md.op_div) begin
            state_d = S_DIV;
            cnt_d   = 5'd31;
            rem_d   = '0;
            quo_d   = (md.is_sign && md.src_a[31]) ? -md.src_a : md.src_a;
            dvs_d   = (md.is_sign && md.src_b[31]) ? -md.src_b : md.src_b;
          end else begin
            state_d = S_MUL;
            cnt_d   = 5'(MUL_LAT - 1);
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        // start stays high here for the same instruction; only release matters
        if (!md.stall_other) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (md.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    md.busy         = (state_q == S_MUL) || (state_q == S_DIV);
    md.stall_md     = rst && (((state_q == S_IDLE) && md.start && !md.flush) || md.busy);
    md.result_valid = (state_q == S_DONE);
    md.hi_out       = hi_q;
    md.lo_out       = lo_q;
  end

endmodule
